// File: rtl/dm_pkg.sv
// Shared types for the MEM-stage data memory.
// Op, exception and state encodings plus the latched request bundle.
package dm_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'b000,
    OP_W    = 3'b001,
    OP_H    = 3'b010,
    OP_B    = 3'b011,
    OP_HU   = 3'b100,
    OP_BU   = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'b00,
    EXC_MISALIGN = 2'b01,
    EXC_RANGE    = 2'b10
  } exc_e;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } dm_req_t;

  function automatic logic is_word(
    input logic [2:0] op
  );
    return op == OP_W;
  endfunction

  function automatic logic is_half(
    input logic [2:0] op
  );
    return op == OP_H || op == OP_HU;
  endfunction

  function automatic logic is_byte(
    input logic [2:0] op
  );
    return op == OP_B || op == OP_BU;
  endfunction

endpackage

// File: rtl/dm_lane_merge.sv
// Byte-lane extraction for loads and lane merge for stores.
// Purely combinational; unknown ops yield zero and an untouched word.
module dm_lane_merge
  import dm_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] mem_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = mem_word[{lane, 3'b000} +: 8];
  assign h = lane[1] ? mem_word[31:16]
                     : mem_word[15:0];

  always_comb begin
    load_val   = '0;
    store_word = mem_word;
    unique case (1'b1)
      is_word(op): begin
        load_val   = mem_word;
        store_word = wdata;
      end
      is_half(op): begin
        load_val = (op == OP_HU)
                 ? {16'h0, h}
                 : {{16{h[15]}}, h};
        store_word[{lane[1], 4'b0000} +: 16] =
          wdata[15:0];
      end
      is_byte(op): begin
        load_val = (op == OP_BU)
                 ? {24'h0, b}
                 : {{24{b[7]}}, b};
        store_word[{lane, 3'b000} +: 8] =
          wdata[7:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_mem_ctrl.sv
// MEM-stage data memory: valid/ready requests, wait states,
// sequential post-reset clear, alignment/range faults, store trace.
module dm_mem_ctrl
  import dm_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0,
  parameter bit          TRACE       = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_exc,
  output logic        busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] ram [DEPTH];

  state_e                state;
  logic [DEPTH_LOG2-1:0] clr_idx;
  logic [3:0]            wait_cnt;
  dm_req_t               held;
  dm_req_t               cur;

  logic                  access;
  logic                  commit;
  logic                  op_ok;
  logic                  mis;
  logic                  oor;
  exc_e                  exc;
  logic [31:0]           off;
  logic [DEPTH_LOG2-1:0] widx;
  logic [31:0]           mem_word;
  logic [31:0]           load_val;
  logic [31:0]           store_word;

  // With zero wait states the access uses the live request.
  assign cur = (state == ST_IDLE)
             ? {req_we, req_op, req_addr,
                req_wdata, req_pc}
             : held;

  assign access =
    (state == ST_IDLE && req_valid &&
     WAIT_CYCLES == 0) ||
    (state == ST_WAIT && wait_cnt == 4'd1);

  assign off  = cur.addr - BASE_ADDR;
  assign widx = off[DEPTH_LOG2+1:2];

  assign op_ok = is_word(cur.op) ||
                 is_half(cur.op) ||
                 is_byte(cur.op);

  assign mis =
    (is_word(cur.op) && cur.addr[1:0] != 2'b00) ||
    (is_half(cur.op) && cur.addr[0]);

  // Unsigned compare so addresses below base wrap high.
  assign oor = {1'b0, off} >= (33'd4 << DEPTH_LOG2);

  assign exc = mis ? EXC_MISALIGN
             : oor ? EXC_RANGE
             : EXC_NONE;

  assign commit = access && cur.we && op_ok &&
                  exc == EXC_NONE;

  assign mem_word = ram[widx];

  dm_lane_merge u_lane (
    .op         (cur.op),
    .lane       (cur.addr[1:0]),
    .mem_word   (mem_word),
    .wdata      (cur.wdata),
    .load_val   (load_val),
    .store_word (store_word)
  );

  always_ff @(posedge clk) begin
    if (state == ST_CLEAR)
      ram[clr_idx] <= '0;
    else if (commit)
      ram[widx] <= store_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_CLEAR;
      clr_idx    <= '0;
      wait_cnt   <= '0;
      held       <= '0;
      busy       <= 1'b1;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_exc   <= EXC_NONE;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        ST_CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == '1) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (req_valid) begin
            held      <= cur;
            req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state <= ST_RESP;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= 4'(WAIT_CYCLES);
            end
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_cnt == 4'd1)
            state <= ST_RESP;
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
        default: state <= ST_CLEAR;
      endcase
      if (access) begin
        resp_valid <= 1'b1;
        resp_exc   <= exc;
        resp_rdata <=
          (!cur.we && op_ok && exc == EXC_NONE)
          ? load_val : '0;
      end
    end
  end

  if (TRACE) begin : g_trace
    always_ff @(posedge clk) begin
      if (commit)
        $write("@%08h: *%08h <= %08h\n",
               cur.pc, cur.addr, store_word);
    end
  end

endmodule

// File: tb/tb_dm_mem_ctrl.sv
// Directed bench: instance 0 has no wait states, instance 1 has three.
// Both use a 16-word memory at base 0.
module tb_dm_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic        valid [2];
  logic        ready [2];
  logic        we    [2];
  logic [2:0]  op    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] pc    [2];
  logic        rv    [2];
  logic [31:0] rdata [2];
  logic [1:0]  exc   [2];
  logic        busy  [2];

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  always #5 clk = ~clk;

  dm_mem_ctrl #(
    .DEPTH_LOG2(4), .BASE_ADDR(32'h0),
    .WAIT_CYCLES(0), .TRACE(1'b1)
  ) dut0 (
    .clk(clk), .reset(rst[0]),
    .req_valid(valid[0]), .req_ready(ready[0]),
    .req_we(we[0]), .req_op(op[0]),
    .req_addr(addr[0]), .req_wdata(wdata[0]),
    .req_pc(pc[0]), .resp_valid(rv[0]),
    .resp_rdata(rdata[0]), .resp_exc(exc[0]),
    .busy(busy[0])
  );

  dm_mem_ctrl #(
    .DEPTH_LOG2(4), .BASE_ADDR(32'h0),
    .WAIT_CYCLES(3), .TRACE(1'b1)
  ) dut1 (
    .clk(clk), .reset(rst[1]),
    .req_valid(valid[1]), .req_ready(ready[1]),
    .req_we(we[1]), .req_op(op[1]),
    .req_addr(addr[1]), .req_wdata(wdata[1]),
    .req_pc(pc[1]), .resp_valid(rv[1]),
    .resp_rdata(rdata[1]), .resp_exc(exc[1]),
    .busy(busy[1])
  );

  // One request; a missing response returns X data and lat = -1.
  task automatic req(
    input  int          s,
    input  logic        w,
    input  logic [2:0]  o,
    input  logic [31:0] ad,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic [1:0]  ex,
    output int          lat
  );
    int n;
    @(negedge clk);
    valid[s] = 1'b1;
    we[s]    = w;
    op[s]    = o;
    addr[s]  = ad;
    wdata[s] = wd;
    pc[s]    = pc_ctr;
    pc_ctr   = pc_ctr + 4;
    n = 0;
    while (!ready[s] && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    valid[s] = 1'b0;
    lat = 1;
    while (!rv[s] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (rv[s]) begin
      rd = rdata[s];
      ex = exc[s];
    end else begin
      rd  = 'x;
      ex  = 'x;
      lat = -1;
    end
  endtask

  task automatic test_reset(input int s);
    int cnt;
    rst[s] = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy[s] !== 1'b1) begin
      n_err++;
      $display("FAIL rst_busy[%0d]: got %b want 1", s, busy[s]);
    end
    n_cmp++;
    if (ready[s] !== 1'b0) begin
      n_err++;
      $display("FAIL rst_ready[%0d]: got %b want 0", s, ready[s]);
    end
    n_cmp++;
    if (rv[s] !== 1'b0) begin
      n_err++;
      $display("FAIL rst_rv[%0d]: got %b want 0", s, rv[s]);
    end
    n_cmp++;
    if (rdata[s] !== 32'h0 || exc[s] !== 2'b00) begin
      n_err++;
      $display("FAIL rst_resp[%0d]: got %h/%b want 0/00",
               s, rdata[s], exc[s]);
    end
    rst[s] = 1'b1;
    cnt = 0;
    while (busy[s] && cnt < 100) begin
      n_cmp++;
      if (ready[s] !== 1'b0) begin
        n_err++;
        $display("FAIL clr_ready[%0d]: got %b want 0 at %0d",
                 s, ready[s], cnt);
      end
      @(negedge clk);
      cnt++;
    end
    n_cmp++;
    if (cnt !== 16) begin
      n_err++;
      $display("FAIL clr_len[%0d]: got %0d want 16", s, cnt);
    end
    n_cmp++;
    if (ready[s] !== 1'b1) begin
      n_err++;
      $display("FAIL post_clr_ready[%0d]: got %b want 1", s, ready[s]);
    end
  endtask

  task automatic test_latency(input int s, input int want);
    logic [31:0] rd;
    logic [1:0]  ex;
    int          lat;
    req(s, 1'b0, 3'b001, 32'h0, 32'h0, rd, ex, lat);
    n_cmp++;
    if (lat !== want) begin
      n_err++;
      $display("FAIL latency[%0d]: got %0d want %0d", s, lat, want);
    end
    n_cmp++;
    if (rd !== 32'h0 || ex !== 2'b00) begin
      n_err++;
      $display("FAIL lw0[%0d]: got %h/%b want 0/00", s, rd, ex);
    end
  endtask

  task automatic test_load_ext;
    logic [31:0] rd;
    logic [1:0]  ex;
    int          lat;
    logic [2:0]  ops [8];
    logic [31:0] ads [8];
    logic [31:0] exp [8];
    ops = '{3'b011, 3'b011, 3'b010, 3'b011,
            3'b101, 3'b010, 3'b100, 3'b001};
    ads = '{32'h9, 32'hB, 32'hA, 32'h12,
            32'h12, 32'h12, 32'h12, 32'h8};
    exp = '{32'h0000_0056, 32'h0000_0012,
            32'h0000_1234, 32'hFFFF_FFFF,
            32'h0000_00FF, 32'hFFFF_80FF,
            32'h0000_80FF, 32'h1234_5678};
    req(0, 1'b1, 3'b001, 32'h8, 32'h1234_5678, rd, ex, lat);
    req(0, 1'b1, 3'b001, 32'h10, 32'h80FF_7F01, rd, ex, lat);
    n_cmp++;
    if (ex !== 2'b00) begin
      n_err++;
      $display("FAIL sw10_exc: got %b want 00", ex);
    end
    for (int i = 0; i < 8; i++) begin
      req(0, 1'b0, ops[i], ads[i], 32'h0, rd, ex, lat);
      n_cmp++;
      if (rd !== exp[i] || ex !== 2'b00) begin
        n_err++;
        $display("FAIL load_ext[%0d] op=%b a=%h: got %h/%b want %h/00",
                 i, ops[i], ads[i], rd, ex, exp[i]);
      end
    end
  endtask

  task automatic test_store_merge;
    logic [31:0] rd;
    logic [1:0]  ex;
    int          lat;
    req(0, 1'b1, 3'b011, 32'h11, 32'hAABB_CCDD, rd, ex, lat);
    req(0, 1'b0, 3'b001, 32'h10, 32'h0, rd, ex, lat);
    n_cmp++;
    if (rd !== 32'h80FF_DD01) begin
      n_err++;
      $display("FAIL sb_merge: got %h want 80ffdd01", rd);
    end
    req(0, 1'b1, 3'b010, 32'h12, 32'h0000_BEEF, rd, ex, lat);
    req(0, 1'b0, 3'b001, 32'h10, 32'h0, rd, ex, lat);
    n_cmp++;
    if (rd !== 32'hBEEF_DD01) begin
      n_err++;
      $display("FAIL sh_merge: got %h want beefdd01", rd);
    end
    req(0, 1'b1, 3'b101, 32'h13, 32'h0000_0042, rd, ex, lat);
    req(0, 1'b0, 3'b001, 32'h10, 32'h0, rd, ex, lat);
    n_cmp++;
    if (rd !== 32'h42EF_DD01) begin
      n_err++;
      $display("FAIL sbu_merge: got %h want 42efdd01", rd);
    end
  endtask

  task automatic test_exceptions;
    logic [31:0] rd;
    logic [1:0]  ex;
    int          lat;
    req(0, 1'b0, 3'b001, 32'h6, 32'h0, rd, ex, lat);
    n_cmp++;
    if (rd !== 32'h0 || ex !== 2'b01) begin
      n_err++;
      $display("FAIL lw_mis: got %h/%b want 0/01", rd, ex);
    end
    req(0, 1'b1, 3'b001, 32'h4, 32'h1122_3344, rd, ex, lat);
    req(0, 1'b1, 3'b001, 32'h6, 32'hFFFF_FFFF, rd, ex, lat);
    n_cmp++;
    if (ex !== 2'b01) begin
      n_err++;
      $display("FAIL sw_mis: got %b want 01", ex);
    end
    req(0, 1'b0, 3'b001, 32'h4, 32'h0, rd, ex, lat);
    n_cmp++;
    if (rd !== 32'h1122_3344 || ex !== 2'b00) begin
      n_err++;
      $display("FAIL sw_mis_nowrite: got %h/%b want 11223344/00",
               rd, ex);
    end
    req(0, 1'b0, 3'b001, 32'h40, 32'h0, rd, ex, lat);
    n_cmp++;
    if (rd !== 32'h0 || ex !== 2'b10) begin
      n_err++;
      $display("FAIL lw_oor: got %h/%b want 0/10", rd, ex);
    end
    req(0, 1'b1, 3'b010, 32'h41, 32'h0, rd, ex, lat);
    n_cmp++;
    if (ex !== 2'b01) begin
      n_err++;
      $display("FAIL sh_prio: got %b want 01", ex);
    end
    req(0, 1'b1, 3'b001, 32'h3C, 32'hCAFE_F00D, rd, ex, lat);
    req(0, 1'b0, 3'b001, 32'h3C, 32'h0, rd, ex, lat);
    n_cmp++;
    if (rd !== 32'hCAFE_F00D || ex !== 2'b00) begin
      n_err++;
      $display("FAIL lw_top: got %h/%b want cafef00d/00", rd, ex);
    end
    req(0, 1'b1, 3'b001, 32'h40, 32'h5555_5555, rd, ex, lat);
    req(0, 1'b0, 3'b001, 32'h0, 32'h0, rd, ex, lat);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_err++;
      $display("FAIL oor_nowrap: got %h want 0", rd);
    end
  endtask

  task automatic test_back_to_back(input int s, input int win, input int want);
    int pulses;
    @(negedge clk);
    valid[s] = 1'b1;
    we[s]    = 1'b0;
    op[s]    = 3'b001;
    addr[s]  = 32'h8;
    pulses   = 0;
    for (int i = 0; i < win; i++) begin
      @(negedge clk);
      if (rv[s]) pulses++;
    end
    valid[s] = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (pulses !== want) begin
      n_err++;
      $display("FAIL b2b[%0d]: got %0d pulses want %0d", s, pulses, want);
    end
  endtask

  task automatic test_reset_midreq;
    logic [31:0] rd;
    logic [1:0]  ex;
    int          lat;
    int          seen;
    int          n;
    @(negedge clk);
    valid[1] = 1'b1;
    we[1]    = 1'b1;
    op[1]    = 3'b001;
    addr[1]  = 32'h0;
    wdata[1] = 32'hDEAD_BEEF;
    pc[1]    = 32'h0000_0BAD;
    n = 0;
    while (!ready[1] && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    valid[1] = 1'b0;
    seen = 0;
    @(negedge clk);
    rst[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rv[1]) seen++;
    end
    n_cmp++;
    if (busy[1] !== 1'b1) begin
      n_err++;
      $display("FAIL mid_rst_busy: got %b want 1", busy[1]);
    end
    rst[1] = 1'b1;
    n = 0;
    while (busy[1] && n < 100) begin
      @(negedge clk);
      if (rv[1]) seen++;
      n++;
    end
    n_cmp++;
    if (seen !== 0 || n !== 16) begin
      n_err++;
      $display("FAIL mid_rst_drop: got %0d pulses/%0d clr want 0/16",
               seen, n);
    end
    req(1, 1'b0, 3'b001, 32'h0, 32'h0, rd, ex, lat);
    n_cmp++;
    if (rd !== 32'h0 || ex !== 2'b00 || lat !== 4) begin
      n_err++;
      $display("FAIL mid_rst_lw0: got %h/%b/%0d want 0/00/4",
               rd, ex, lat);
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst[s]   = 1'b0;
      valid[s] = 1'b0;
      we[s]    = 1'b0;
      op[s]    = 3'b000;
      addr[s]  = '0;
      wdata[s] = '0;
      pc[s]    = '0;
    end
    test_reset(0);
    test_latency(0, 1);
    test_load_ext;
    test_store_merge;
    test_exceptions;
    test_back_to_back(0, 12, 6);
    test_reset(1);
    test_latency(1, 4);
    test_back_to_back(1, 20, 4);
    test_reset_midreq;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
